// File: rtl/boss_pkg.sv
// Shared encodings and geometry for the stage-3 boss controller, its animation
// helper and the downstream sprite renderer.
package boss_pkg;

    localparam logic [3:0] GS_STAGE3   = 4'd6;
    localparam logic [3:0] GS_SUCCESS3 = 4'd7;
    localparam logic [3:0] GS_FAIL     = 4'd8;

    // OFF idle/reset | ENTER descend | PATROL sweep x | CHARGE dive | RETURN climb | DEAD frozen
    typedef enum logic [2:0] {
        B_OFF    = 3'd0,
        B_ENTER  = 3'd1,
        B_PATROL = 3'd2,
        B_CHARGE = 3'd3,
        B_RETURN = 3'd4,
        B_DEAD   = 3'd5
    } boss_fsm_t;

    localparam logic [3:0] FRAME_FLASH = 4'd4;
    localparam logic [3:0] FRAME_DEAD  = 4'd5;

    localparam int SCREEN_W      = 320;
    localparam int SCREEN_H      = 240;
    localparam int SPRITE        = 10;
    localparam int X_MAX         = SCREEN_W - SPRITE;
    localparam int Y_MAX         = SCREEN_H - SPRITE;
    localparam int START_X       = 155;
    localparam int PATROL_Y      = 40;
    localparam int SPEED         = 2;
    localparam int ANIM_DIV      = 8;
    localparam int HP_INIT       = 8;
    localparam int CHARGE_PERIOD = 120;
    localparam int HIT_FLASH     = 16;

    function automatic logic is_moving(input boss_fsm_t s);
        return (s == B_PATROL) || (s == B_CHARGE) || (s == B_RETURN);
    endfunction

endpackage

// File: rtl/boss_anim.sv
// Walk-frame divider, hit-flash timer and the registered boss_state priority mux.
module boss_anim
    import boss_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_frame_tick,
    input  logic       i_moving,
    input  logic       i_hit_accept,
    input  logic       i_dead,
    output logic       o_flash_idle,
    output logic [3:0] o_boss_state
);

    logic [2:0] r_walk_cnt;
    logic [1:0] r_frame;
    logic [4:0] r_flash;
    logic [3:0] r_boss_state;

    logic [2:0] w_walk_next;
    logic [1:0] w_frame_next;
    logic [4:0] w_flash_next;

    always_comb begin
        w_walk_next  = r_walk_cnt;
        w_frame_next = r_frame;
        w_flash_next = r_flash;
        if (i_frame_tick && i_moving) begin
            if (r_walk_cnt == 3'(ANIM_DIV - 1)) begin
                w_walk_next  = 3'd0;
                w_frame_next = r_frame + 2'd1;
            end else begin
                w_walk_next = r_walk_cnt + 3'd1;
            end
        end
        if (i_hit_accept) begin
            w_flash_next = 5'(HIT_FLASH);
        end else if (i_frame_tick && (r_flash != 5'd0)) begin
            w_flash_next = r_flash - 5'd1;
        end
    end

    // The mux looks at next-state values so boss_state lines up with the other outputs.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_walk_cnt   <= 3'd0;
            r_frame      <= 2'd0;
            r_flash      <= 5'd0;
            r_boss_state <= 4'd0;
        end else begin
            r_walk_cnt <= w_walk_next;
            r_frame    <= w_frame_next;
            r_flash    <= w_flash_next;
            if (i_dead)
                r_boss_state <= FRAME_DEAD;
            else if ((w_flash_next != 5'd0) && w_flash_next[2])
                r_boss_state <= FRAME_FLASH;
            else
                r_boss_state <= {2'b00, w_frame_next};
        end
    end

    assign o_flash_idle = (r_flash == 5'd0);
    assign o_boss_state = r_boss_state;

endmodule

// File: rtl/boss_ctrl.sv
// Stage-3 boss controller: position, hit points and behaviour FSM feeding the
// boss sprite renderer. Movement advances once per frame_tick.
module boss_ctrl
    import boss_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_state,
    input  logic       i_frame_tick,
    input  logic [8:0] i_player_y,
    input  logic       i_hit,
    output logic [8:0] o_boss_x,
    output logic [8:0] o_boss_y,
    output logic [3:0] o_boss_state,
    output logic [3:0] o_boss_hp,
    output logic       o_boss_dead
);

    localparam logic signed [9:0] X_MAX_S = 10'(X_MAX);
    localparam logic signed [9:0] SPEED_S = 10'(SPEED);

    boss_fsm_t  r_fsm;
    logic [8:0] r_x;
    logic [8:0] r_y;
    logic [8:0] r_charge_y;
    logic       r_dir_left;
    logic [3:0] r_hp;
    logic       r_dead;
    logic [6:0] r_charge_cnt;

    logic              w_clr;
    logic              w_moving;
    logic              w_flash_idle;
    logic              w_hit_accept;
    logic              w_dying;
    logic              w_dead_next;
    logic signed [9:0] w_x_sum;
    logic [9:0]        w_y_charge;
    logic [8:0]        w_charge_y;

    assign w_clr        = i_rst || (i_state != GS_STAGE3);
    assign w_moving     = is_moving(r_fsm);
    assign w_hit_accept = i_hit && w_moving && w_flash_idle && (r_hp != 4'd0) && !w_clr;
    assign w_dying      = w_hit_accept && (r_hp == 4'd1);
    assign w_dead_next  = !w_clr && (r_dead || w_dying);

    // x is evaluated in 10 signed bits so a step past either wall is visible before clamping.
    assign w_x_sum    = r_dir_left ? ($signed({1'b0, r_x}) - SPEED_S)
                                   : ($signed({1'b0, r_x}) + SPEED_S);
    assign w_y_charge = {1'b0, r_y} + 10'(2 * SPEED);
    assign w_charge_y = (i_player_y > 9'(Y_MAX)) ? 9'(Y_MAX) : i_player_y;

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_fsm        <= B_OFF;
            r_x          <= 9'(START_X);
            r_y          <= 9'd0;
            r_charge_y   <= 9'd0;
            r_dir_left   <= 1'b0;
            r_hp         <= 4'(HP_INIT);
            r_dead       <= 1'b0;
            r_charge_cnt <= 7'd0;
        end else begin
            if (w_hit_accept)
                r_hp <= r_hp - 4'd1;
            case (r_fsm)
                B_OFF: r_fsm <= B_ENTER;
                B_ENTER: begin
                    if (i_frame_tick) begin
                        r_y <= r_y + 9'd1;
                        if (r_y == 9'(PATROL_Y - 1)) begin
                            r_fsm        <= B_PATROL;
                            r_dir_left   <= 1'b0;
                            r_charge_cnt <= 7'd0;
                        end
                    end
                end
                B_PATROL: begin
                    if (i_frame_tick) begin
                        if (r_charge_cnt == 7'(CHARGE_PERIOD - 1)) begin
                            r_charge_cnt <= 7'd0;
                            r_charge_y   <= w_charge_y;
                            r_fsm        <= B_CHARGE;
                        end else begin
                            r_charge_cnt <= r_charge_cnt + 7'd1;
                            if (w_x_sum < 10'sd0) begin
                                r_x        <= 9'd0;
                                r_dir_left <= 1'b0;
                            end else if (w_x_sum > X_MAX_S) begin
                                r_x        <= 9'(X_MAX);
                                r_dir_left <= 1'b1;
                            end else begin
                                r_x <= w_x_sum[8:0];
                            end
                        end
                    end
                end
                B_CHARGE: begin
                    if (r_charge_y <= 9'(PATROL_Y)) begin
                        r_fsm <= B_RETURN;
                    end else if (i_frame_tick) begin
                        if (w_y_charge >= {1'b0, r_charge_y}) begin
                            r_y   <= r_charge_y;
                            r_fsm <= B_RETURN;
                        end else begin
                            r_y <= w_y_charge[8:0];
                        end
                    end
                end
                B_RETURN: begin
                    if (i_frame_tick) begin
                        if (r_y <= 9'(PATROL_Y + SPEED)) begin
                            r_y   <= 9'(PATROL_Y);
                            r_fsm <= B_PATROL;
                        end else begin
                            r_y <= r_y - 9'(SPEED);
                        end
                    end
                end
                B_DEAD:  r_fsm <= B_DEAD;
                default: r_fsm <= B_OFF;
            endcase
            if (w_dying) begin
                r_fsm  <= B_DEAD;
                r_dead <= 1'b1;
            end
        end
    end

    boss_anim u_anim (
        .i_clk        (i_clk),
        .i_clr        (w_clr),
        .i_frame_tick (i_frame_tick),
        .i_moving     (w_moving),
        .i_hit_accept (w_hit_accept),
        .i_dead       (w_dead_next),
        .o_flash_idle (w_flash_idle),
        .o_boss_state (o_boss_state)
    );

    assign o_boss_x    = r_x;
    assign o_boss_y    = r_y;
    assign o_boss_hp   = r_hp;
    assign o_boss_dead = r_dead;

endmodule

// File: tb/tb_boss_ctrl.sv
// Directed bench for boss_ctrl: entry, patrol walls, charge/return, hit flash,
// death freeze and abort via state change or reset.
module tb_boss_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] state = 4'd0;
    logic       frame_tick = 1'b0;
    logic [8:0] player_y = 9'd0;
    logic       hit = 1'b0;
    logic [8:0] boss_x;
    logic [8:0] boss_y;
    logic [3:0] boss_state;
    logic [3:0] boss_hp;
    logic       boss_dead;

    int checks = 0;
    int errors = 0;

    boss_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_state      (state),
        .i_frame_tick (frame_tick),
        .i_player_y   (player_y),
        .i_hit        (hit),
        .o_boss_x     (boss_x),
        .o_boss_y     (boss_y),
        .o_boss_state (boss_state),
        .o_boss_hp    (boss_hp),
        .o_boss_dead  (boss_dead)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // one frame_tick every 4 clks; returns on a negedge with the tick's effect visible
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse_hit();
        @(negedge clk) hit = 1'b1;
        @(negedge clk) hit = 1'b0;
    endtask

    task automatic tick_with_hit();
        @(negedge clk) begin frame_tick = 1'b1; hit = 1'b1; end
        @(negedge clk) begin frame_tick = 1'b0; hit = 1'b0; end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; state = 4'd0;
        repeat (3) @(negedge clk);
        checks++; if (boss_x !== 9'd155) begin errors++; $display("FAIL reset_x got %0d exp 155", boss_x); end
        checks++; if (boss_y !== 9'd0) begin errors++; $display("FAIL reset_y got %0d exp 0", boss_y); end
        checks++; if (boss_state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", boss_state); end
        checks++; if (boss_hp !== 4'd8) begin errors++; $display("FAIL reset_hp got %0d exp 8", boss_hp); end
        checks++; if (boss_dead !== 1'b0) begin errors++; $display("FAIL reset_dead got %0d exp 0", boss_dead); end
    endtask

    task automatic test_enter();
        rst = 1'b0; state = 4'd6;
        @(negedge clk);
        pulse_hit();
        checks++; if (boss_hp !== 4'd8) begin errors++; $display("FAIL enter_hit_ignored hp got %0d exp 8", boss_hp); end
        tick(39);
        checks++; if (boss_y !== 9'd39) begin errors++; $display("FAIL enter_y39 got %0d exp 39", boss_y); end
        tick(1);
        checks++; if (boss_y !== 9'd40) begin errors++; $display("FAIL enter_y40 got %0d exp 40", boss_y); end
        checks++; if (boss_x !== 9'd155) begin errors++; $display("FAIL enter_x got %0d exp 155", boss_x); end
        checks++; if (boss_state !== 4'd0) begin errors++; $display("FAIL enter_frame got %0d exp 0", boss_state); end
    endtask

    task automatic test_patrol();
        tick(77);
        checks++; if (boss_x !== 9'd309) begin errors++; $display("FAIL patrol_x309 got %0d exp 309", boss_x); end
        checks++; if (boss_state !== 4'd1) begin errors++; $display("FAIL patrol_frame77 got %0d exp 1", boss_state); end
        tick(1);
        checks++; if (boss_x !== 9'd310) begin errors++; $display("FAIL patrol_clamp310 got %0d exp 310", boss_x); end
        tick(1);
        checks++; if (boss_x !== 9'd308) begin errors++; $display("FAIL patrol_turn308 got %0d exp 308", boss_x); end
        tick(40);
        checks++; if (boss_x !== 9'd228) begin errors++; $display("FAIL patrol_x228 got %0d exp 228", boss_x); end
        player_y = 9'd200;
        tick(1);
        checks++; if (boss_x !== 9'd228) begin errors++; $display("FAIL charge_entry_x_hold got %0d exp 228", boss_x); end
        checks++; if (boss_y !== 9'd40) begin errors++; $display("FAIL charge_entry_y got %0d exp 40", boss_y); end
    endtask

    task automatic test_charge();
        tick(1);
        checks++; if (boss_y !== 9'd44) begin errors++; $display("FAIL charge_y44 got %0d exp 44", boss_y); end
        tick(39);
        checks++; if (boss_y !== 9'd200) begin errors++; $display("FAIL charge_y200 got %0d exp 200", boss_y); end
        checks++; if (boss_x !== 9'd228) begin errors++; $display("FAIL charge_x got %0d exp 228", boss_x); end
        tick(1);
        checks++; if (boss_y !== 9'd198) begin errors++; $display("FAIL return_y198 got %0d exp 198", boss_y); end
        tick(79);
        checks++; if (boss_y !== 9'd40) begin errors++; $display("FAIL return_y40 got %0d exp 40", boss_y); end
        tick(1);
        checks++; if (boss_x !== 9'd226) begin errors++; $display("FAIL repatrol_x got %0d exp 226", boss_x); end
        checks++; if (boss_y !== 9'd40) begin errors++; $display("FAIL repatrol_y got %0d exp 40", boss_y); end
    endtask

    task automatic test_hit();
        pulse_hit();
        checks++; if (boss_hp !== 4'd7) begin errors++; $display("FAIL hit_hp7 got %0d exp 7", boss_hp); end
        checks++; if (boss_state !== 4'd2) begin errors++; $display("FAIL hit_flash16 state got %0d exp 2", boss_state); end
        tick(1);
        checks++; if (boss_state !== 4'd4) begin errors++; $display("FAIL flash_k1 state got %0d exp 4", boss_state); end
        tick(3);
        checks++; if (boss_state !== 4'd4) begin errors++; $display("FAIL flash_k4 state got %0d exp 4", boss_state); end
        tick(1);
        checks++; if (boss_state !== 4'd2) begin errors++; $display("FAIL flash_k5 state got %0d exp 2", boss_state); end
        tick(3);
        checks++; if (boss_state !== 4'd3) begin errors++; $display("FAIL flash_k8 state got %0d exp 3", boss_state); end
        tick(1);
        checks++; if (boss_state !== 4'd4) begin errors++; $display("FAIL flash_k9 state got %0d exp 4", boss_state); end
        pulse_hit();
        checks++; if (boss_hp !== 4'd7) begin errors++; $display("FAIL hit_during_flash hp got %0d exp 7", boss_hp); end
        tick(7);
        checks++; if (boss_state !== 4'd0) begin errors++; $display("FAIL flash_end state got %0d exp 0", boss_state); end
        checks++; if (boss_x !== 9'd194) begin errors++; $display("FAIL hit_patrol_x got %0d exp 194", boss_x); end
        tick_with_hit();
        checks++; if (boss_x !== 9'd192) begin errors++; $display("FAIL hit_tick_same_clk x got %0d exp 192", boss_x); end
        checks++; if (boss_hp !== 4'd6) begin errors++; $display("FAIL hit_tick_same_clk hp got %0d exp 6", boss_hp); end
    endtask

    task automatic test_dead();
        state = 4'd0;
        @(negedge clk);
        state = 4'd6;
        @(negedge clk);
        tick(40);
        checks++; if (boss_y !== 9'd40) begin errors++; $display("FAIL dead_setup_y got %0d exp 40", boss_y); end
        pulse_hit();
        for (int k = 2; k <= 8; k++) begin
            tick(17);
            pulse_hit();
            if (k == 7) begin
                checks++; if (boss_hp !== 4'd1) begin errors++; $display("FAIL hp_after7 got %0d exp 1", boss_hp); end
            end
        end
        checks++; if (boss_hp !== 4'd0) begin errors++; $display("FAIL dead_hp got %0d exp 0", boss_hp); end
        checks++; if (boss_dead !== 1'b1) begin errors++; $display("FAIL dead_flag got %0d exp 1", boss_dead); end
        checks++; if (boss_state !== 4'd5) begin errors++; $display("FAIL dead_state got %0d exp 5", boss_state); end
        tick(50);
        pulse_hit();
        checks++; if (boss_x !== 9'd228) begin errors++; $display("FAIL dead_frozen_x got %0d exp 228", boss_x); end
        checks++; if (boss_y !== 9'd40) begin errors++; $display("FAIL dead_frozen_y got %0d exp 40", boss_y); end
        checks++; if (boss_state !== 4'd5) begin errors++; $display("FAIL dead_hold_state got %0d exp 5", boss_state); end
        checks++; if (boss_dead !== 1'b1) begin errors++; $display("FAIL dead_hold_flag got %0d exp 1", boss_dead); end
        checks++; if (boss_hp !== 4'd0) begin errors++; $display("FAIL dead_hold_hp got %0d exp 0", boss_hp); end
    endtask

    task automatic test_clamp_abort();
        state = 4'd0;
        @(negedge clk);
        state = 4'd6;
        player_y = 9'd239;
        @(negedge clk);
        tick(40);
        tick(120);
        tick(47);
        checks++; if (boss_y !== 9'd228) begin errors++; $display("FAIL clamp_y228 got %0d exp 228", boss_y); end
        tick(1);
        checks++; if (boss_y !== 9'd230) begin errors++; $display("FAIL clamp_y230 got %0d exp 230", boss_y); end
        tick(95);
        checks++; if (boss_y !== 9'd40) begin errors++; $display("FAIL clamp_return_y got %0d exp 40", boss_y); end
        tick(120);
        tick(10);
        checks++; if (boss_y !== 9'd80) begin errors++; $display("FAIL charge2_y80 got %0d exp 80", boss_y); end
        pulse_hit();
        checks++; if (boss_hp !== 4'd7) begin errors++; $display("FAIL charge_hit hp got %0d exp 7", boss_hp); end
        tick(1);
        checks++; if (boss_state !== 4'd4) begin errors++; $display("FAIL charge_flash state got %0d exp 4", boss_state); end
        @(negedge clk) state = 4'd8;
        @(negedge clk);
        checks++; if (boss_x !== 9'd155) begin errors++; $display("FAIL abort_x got %0d exp 155", boss_x); end
        checks++; if (boss_y !== 9'd0) begin errors++; $display("FAIL abort_y got %0d exp 0", boss_y); end
        checks++; if (boss_hp !== 4'd8) begin errors++; $display("FAIL abort_hp got %0d exp 8", boss_hp); end
        checks++; if (boss_dead !== 1'b0) begin errors++; $display("FAIL abort_dead got %0d exp 0", boss_dead); end
        checks++; if (boss_state !== 4'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", boss_state); end
    endtask

    task automatic test_reset_mid_flash();
        state = 4'd6;
        @(negedge clk);
        tick(40);
        pulse_hit();
        tick(1);
        checks++; if (boss_state !== 4'd4) begin errors++; $display("FAIL preflash state got %0d exp 4", boss_state); end
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        checks++; if (boss_x !== 9'd155) begin errors++; $display("FAIL rst_x got %0d exp 155", boss_x); end
        checks++; if (boss_y !== 9'd0) begin errors++; $display("FAIL rst_y got %0d exp 0", boss_y); end
        checks++; if (boss_hp !== 4'd8) begin errors++; $display("FAIL rst_hp got %0d exp 8", boss_hp); end
        checks++; if (boss_dead !== 1'b0) begin errors++; $display("FAIL rst_dead got %0d exp 0", boss_dead); end
        checks++; if (boss_state !== 4'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", boss_state); end
        @(negedge clk);
        checks++; if (boss_state !== 4'd0) begin errors++; $display("FAIL rst_flash_cleared state got %0d exp 0", boss_state); end
        tick(40);
        pulse_hit();
        checks++; if (boss_hp !== 4'd7) begin errors++; $display("FAIL post_rst_hit hp got %0d exp 7", boss_hp); end
    endtask

    initial begin
        test_reset();
        test_enter();
        test_patrol();
        test_charge();
        test_hit();
        test_dead();
        test_clamp_abort();
        test_reset_mid_flash();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
